// File: rtl/mul_booth_seq.sv
// Sequential radix-4 Booth multiplier: one partial product per cycle into a 2W+2-bit accumulator.
// Optional early termination when the remaining multiplier digits are all zero: define MUL_BOOTH_EARLY_TERM_EN.
module mul_booth_seq #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_x_signed,
    input  logic                      in_y_signed,
    input  logic [DATA_WIDTH-1:0]     in_x,
    input  logic [DATA_WIDTH-1:0]     in_y,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   out_product,
    output logic                      busy
);
    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned PW   = 2 * W + 2;
    localparam int unsigned MW   = W + 3;
    localparam int unsigned LAST = W / 2;
    localparam int unsigned CW   = $clog2(LAST + 2);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e            state_q;
    logic [PW-1:0]     mcand_q;
    logic [MW-1:0]     mplier_q;
    logic [PW-1:0]     acc_q;
    logic [CW-1:0]     cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [2*W-1:0]    product_q;

    logic [PW-1:0]     xe_d;
    logic [MW-1:0]     ye_d;
    logic [PW-1:0]     term;
    logic              neg;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     acc_d;
    logic [PW-1:0]     mcand_d;
    logic [MW-1:0]     mplier_d;
    logic              last_step;

    assign xe_d     = {{(W + 2){in_x_signed & in_x[W-1]}}, in_x};
    assign ye_d     = {{2{in_y_signed & in_y[W-1]}}, in_y, 1'b0};
    assign mcand_d  = {mcand_q[PW-3:0], 2'b00};
    assign mplier_d = {{2{mplier_q[MW-1]}}, mplier_q[MW-1:2]};

    // Negative digits add the inverted term; the +1 rides in as the adder carry-in.
    always_comb begin
        term = '0;
        neg  = 1'b0;
        unique case (mplier_q[2:0])
            3'b001, 3'b010: term = mcand_q;
            3'b011:         term = {mcand_q[PW-2:0], 1'b0};
            3'b100: begin
                term = {mcand_q[PW-2:0], 1'b0};
                neg  = 1'b1;
            end
            3'b101, 3'b110: begin
                term = mcand_q;
                neg  = 1'b1;
            end
            default: ;
        endcase
        pp    = neg ? ~term : term;
        acc_d = acc_q + pp + PW'(neg);
    end

`ifdef MUL_BOOTH_EARLY_TERM_EN
    assign last_step = (cnt_q == CW'(LAST)) || (mplier_d == '0) || (mplier_d == '1);
`else
    assign last_step = (cnt_q == CW'(LAST));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            product_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!flush && in_valid) begin
                        mcand_q    <= xe_d;
                        mplier_q   <= ye_d;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= S_CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        cnt_q    <= cnt_q + CW'(1);
                        if (last_step) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            product_q   <= acc_d[2*W-1:0];
                        end
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign out_product = product_q;

endmodule

// File: tb/tb_mul_booth_seq.sv
// Directed-vector bench for mul_booth_seq (W=32); latency expectations follow MUL_BOOTH_EARLY_TERM_EN.
module tb_mul_booth_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_x_signed = 1'b0;
    logic        in_y_signed = 1'b0;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_product;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

`ifdef MUL_BOOTH_EARLY_TERM_EN
    localparam int LFULL  = -1;
    localparam int LEARLY = 2;
`else
    localparam int LFULL  = 18;
    localparam int LEARLY = 18;
`endif

    mul_booth_seq #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x_signed(in_x_signed),
        .in_y_signed(in_y_signed),
        .in_x       (in_x),
        .in_y       (in_y),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic xs, input logic ys,
                                          input logic [31:0] x, input logic [31:0] y);
        logic signed [65:0] a;
        logic signed [65:0] b;
        logic signed [65:0] p;
        a = xs ? {{34{x[31]}}, x} : {34'b0, x};
        b = ys ? {{34{y[31]}}, y} : {34'b0, y};
        p = a * b;
        return p[63:0];
    endfunction

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic xs, input logic ys,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_x_signed = xs;
        in_y_signed = ys;
        in_x        = x;
        in_y        = y;
        @(negedge clk);
        in_valid    = 1'b0;
        in_x_signed = ~xs;
        in_y_signed = ~ys;
        in_x        = $urandom;
        in_y        = $urandom;
        wait_valid(lat);
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " product"}, out_product, exp);
        if (exp_lat > 0) check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        logic xs, ys;
        logic [31:0] rx, ry;

        #2 rst_n = 1'b0;
        #1;
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst product", out_product, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("ss m1*m1", 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, LEARLY);
        run_op("uu max*max", 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, LFULL);
        run_op("ss min*min", 1, 1, 32'h80000000, 32'h80000000, 64'h4000000000000000, LFULL);
        run_op("su m2*3", 1, 0, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFFFFFFFFFA, LFULL);
        run_op("us 3*m2", 0, 1, 32'd3, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFA, LFULL);
        run_op("ss max*min", 1, 1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, LFULL);
        run_op("uu 5*1", 0, 0, 32'd5, 32'd1, 64'd5, LEARLY);
        run_op("ss x*m1", 1, 1, 32'h00001234, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFEDCC, LEARLY);

        // Backpressure: DONE must hold with stable product and ignore new requests.
        @(negedge clk);
        in_valid = 1'b1; in_x_signed = 1'b0; in_y_signed = 1'b0;
        in_x = 32'hFFFFFFFF; in_y = 32'd2;
        @(negedge clk);
        in_x = 32'd3; in_y = 32'd5;
        wait_valid(lat);
        check("bp first valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp hold valid", 64'(out_valid), 64'd1);
            check("bp hold product", out_product, 64'h00000001FFFFFFFE);
            check("bp hold in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp no turnaround busy", 64'(busy), 64'd0);
        check("bp idle in_ready", 64'(in_ready), 64'd1);
        check("bp idle out_valid", 64'(out_valid), 64'd0);
        check("bp held product", out_product, 64'h00000001FFFFFFFE);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp next accept busy", 64'(busy), 64'd1);
        wait_valid(lat);
        check("bp 3*5", out_product, 64'd15);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Flush during CALC step 5.
        @(negedge clk);
        in_valid = 1'b1; in_x = 32'd7; in_y = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush busy", 64'(busy), 64'd0);
        check("flush product kept", out_product, 64'd15);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush no late valid", 64'(seen), 64'd0);
        run_op("uu 7*9 after flush", 0, 0, 32'd7, 32'd9, 64'd63, LFULL);

        // Flush in IDLE beats in_valid.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_x = 32'd2; in_y = 32'd2;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("idle flush no accept", 64'(busy), 64'd0);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        in_valid = 1'b1; in_x = 32'h1234; in_y = 32'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst product", out_product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("uu 7*9 after reset", 0, 0, 32'd7, 32'd9, 64'd63, LFULL);

        for (int i = 0; i < 100; i++) begin
            xs = 1'($urandom_range(0, 1));
            ys = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = $urandom;
            if (i % 4 == 1) ry = ry >> $urandom_range(0, 31);
            if (i % 4 == 2) ry = ys ? ~(ry >> $urandom_range(0, 31)) : ry;
            run_op("rand", xs, ys, rx, ry, model(xs, ys, rx, ry), LFULL);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
